// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the control
// unit's decode of mult/div requests.
package mdu_pkg;

  localparam int unsigned MDU_ITERS = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic [4:0] CT_MULT = 5'b01010;
  localparam logic [4:0] CT_DIV  = 5'b01001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_WB   = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit writing
// the HI/LO registers after 32 one-bit steps.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            divby0flag
);

  localparam int unsigned CW        = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(MDU_ITERS - 1);

  mdu_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_q, op_d;
  logic            div0_q, div0_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  // Upper accumulator carries one guard bit so Booth add/sub never overflows.
  logic [XLEN:0]   acc_a_q, acc_a_d;
  logic [XLEN-1:0] acc_q_q, acc_q_d;
  logic            qm1_q, qm1_d;
  logic [XLEN:0]   m_q, m_d;
  logic            busy_d, done_d, flag_d;
  logic [XLEN-1:0] hi_d, lo_d;

  logic [XLEN:0]   booth_sum;
  logic [XLEN:0]   r_shift, r_diff;
  logic [XLEN-1:0] mag_a;
  logic [XLEN:0]   mag_b;
  logic [XLEN-1:0] quot, rem;

  // Booth step: add/subtract multiplicand according to {Q0, q_-1}.
  always_comb begin
    booth_sum = acc_a_q;
    unique case ({acc_q_q[0], qm1_q})
      2'b01:   booth_sum = acc_a_q + m_q;
      2'b10:   booth_sum = acc_a_q - m_q;
      default: booth_sum = acc_a_q;
    endcase
  end

  // Restoring step: shift in the next dividend bit, trial-subtract divisor.
  assign r_shift = {acc_a_q[XLEN-1:0], acc_q_q[XLEN-1]};
  assign r_diff  = r_shift - m_q;

  // Unsigned magnitude of the dividend fits XLEN bits even for the most negative value.
  assign mag_a = srca[XLEN-1] ? XLEN'(-srca) : srca;
  assign mag_b = srcb[XLEN-1] ? (XLEN+1)'(-{1'b1, srcb}) : {1'b0, srcb};

  assign quot = (sign_a_q ^ sign_b_q) ? XLEN'(-acc_q_q) : acc_q_q;
  assign rem  = sign_a_q ? XLEN'(-acc_a_q[XLEN-1:0]) : acc_a_q[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    div0_d   = div0_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_a_d  = acc_a_q;
    acc_q_d  = acc_q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    busy_d   = busy;
    done_d   = 1'b0;
    flag_d   = divby0flag;
    hi_d     = hi;
    lo_d     = lo;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d    = '0;
          op_d     = op;
          flag_d   = 1'b0;
          busy_d   = 1'b1;
          acc_a_d  = '0;
          qm1_d    = 1'b0;
          sign_a_d = srca[XLEN-1];
          sign_b_d = srcb[XLEN-1];
          div0_d   = (op == OP_DIV) && (srcb == '0);
          if (op == OP_MULT) begin
            acc_q_d = srcb;
            m_d     = {srca[XLEN-1], srca};
            state_d = ST_MULT;
          end else begin
            acc_q_d = mag_a;
            m_d     = mag_b;
            state_d = (srcb == '0) ? ST_WB : ST_DIV;
          end
        end
      end
      ST_MULT: begin
        acc_a_d = {booth_sum[XLEN], booth_sum[XLEN:1]};
        acc_q_d = {booth_sum[0], acc_q_q[XLEN-1:1]};
        qm1_d   = acc_q_q[0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = ST_WB;
      end
      ST_DIV: begin
        if (!r_diff[XLEN]) begin
          acc_a_d = r_diff;
          acc_q_d = {acc_q_q[XLEN-2:0], 1'b1};
        end else begin
          acc_a_d = r_shift;
          acc_q_d = {acc_q_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (div0_q) begin
          flag_d = 1'b1;
        end else if (op_q == OP_MULT) begin
          hi_d = acc_a_q[XLEN-1:0];
          lo_d = acc_q_q;
        end else begin
          hi_d = rem;
          lo_d = quot;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      div0_q     <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      acc_a_q    <= '0;
      acc_q_q    <= '0;
      qm1_q      <= 1'b0;
      m_q        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      divby0flag <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      div0_q     <= div0_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      acc_a_q    <= acc_a_d;
      acc_q_q    <= acc_q_d;
      qm1_q      <= qm1_d;
      m_q        <= m_d;
      busy       <= busy_d;
      done       <= done_d;
      divby0flag <= flag_d;
      hi         <= hi_d;
      lo         <= lo_d;
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit for the multicycle MIPS datapath. It responds to the control unit's mult/div requests (ControlType 5'b01010 / 5'b01001, and the I-type divm), and computes the result over 32 iteration cycles. Results go into the HI/LO registers; completion and divide-by-zero are reported back to the controller. The controller stalls on `busy` and, on `divby0flag`, branches to its exception sequence.

## Interface
- `XLEN`, 32: operand width; HI and LO are each XLEN bits.
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1: request pulse; accepted only in IDLE.
- `op`  in  1: 0 = MULT, 1 = DIV; sampled with `start`.
- `srca`  in  XLEN: rs operand (multiplicand / dividend), signed two's complement.
- `srcb`  in  XLEN: rt operand (multiplier / divisor), signed two's complement.
- `busy`  out  1: high from the edge that accepts `start` until the writeback edge.
- `done`  out  1: one-cycle pulse after writeback.
- `hi`  out  XLEN: HI register; the upper product word, or the remainder.
- `lo`  out  XLEN: LO register; the lower product word, or the quotient.
- `divby0flag`  out  1: set when a DIV completes with `srcb`==0.

## Operation
- States: IDLE, MULT, DIV, WB.
- IDLE with `start`:
  - latch the operands and `op`; clear the 6-bit iteration counter; clear `divby0flag`;
  - go to MULT or DIV.
- DIV with latched `srcb`==0:
  - no iterations; go straight to WB with `divby0flag` set;
  - `hi` and `lo` are left unchanged.
- MULT:
  - radix-2 Booth over a 65-bit accumulator {A[31:0], Q[31:0], q_-1};
  - one step per cycle; after step 32 go to WB.
- DIV:
  - restoring division on magnitudes |srca| and |srcb|, one quotient bit per cycle;
  - after 32 steps go to WB;
  - the signs are recorded at the start.
- WB (one cycle), writes then returns to IDLE:
  - MULT: {hi,lo} = 64-bit signed product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- Arithmetic rules:
  - 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (wraps); this case is not flagged.
  - Magnitude of 0x80000000 is computed in 33 bits (no overflow).
- `start` while `busy`: ignored and not queued. `op` and operand changes while busy have no effect.
- `hi` and `lo` hold their value between operations; the MFHI/MFLO paths read them directly.
- `divby0flag` holds until the next accepted `start` or `reset`.

## Timing
- Reset values: state = IDLE; `busy`=0; `done`=0; `divby0flag`=0; `hi`=0; `lo`=0; counter = 0.
- `start` sampled at edge N.
- MULT or DIV with nonzero divisor:
  - iterations on edges N+1 … N+32;
  - writeback on edge N+33;
  - `done`=1 and new `hi`/`lo` visible in the cycle after N+33;
  - `busy` is high during the cycles after edges N … N+32.
- DIV by zero:
  - writeback on edge N+1;
  - `done`=1 and `divby0flag`=1 in the cycle after N+1.
- `done` falls on the next edge. A new `start` is accepted in the same cycle that `done` is high (state is IDLE then).
- `reset` mid-operation wins over everything:
  - all outputs return to their reset values on that edge;
  - the partial result is discarded.
- `reset` and `start` on the same edge: reset wins and `start` is dropped.

## Structure
- Shared package `mdu_pkg` holds:
  - `OP_MULT`=1'b0, `OP_DIV`=1'b1;
  - the state encoding IDLE/MULT/DIV/WB;
  - `MDU_ITERS`=32;
  - the ControlType codes `CT_MULT`=5'b01010 and `CT_DIV`=5'b01001, so the control unit and the decode glue share one definition.
- No sub-module. The Booth step and the restoring step are small combinational blocks inside this module, selected by state.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` exactly 34 cycles after `start`; `busy` high for 33 cycles.
- MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000; MULT 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0, `lo`=1.
- DIV 100 / −7 → `lo`=0xFFFFFFF2, `hi`=0x00000002. DIV −100 / 7 → `lo`=0xFFFFFFF2, `hi`=0xFFFFFFFE. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIV 5 / 0 with prior `hi`=0x1234, `lo`=0x5678 → `done` and `divby0flag` high 2 cycles after `start`; `hi`/`lo` unchanged; the flag clears on the next `start`.
- Second `start` (MULT 2×3) asserted during a busy DIV 9/2 → ignored; the result is `lo`=4, `hi`=1 at the original latency.
- `reset` asserted at iteration 10 of a MULT → next cycle all outputs are 0 and the state is IDLE; a following MULT 6×7 gives `lo`=42, `hi`=0.
